pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard / flush / freeze controller for a classic 5-stage in-order pipeline.
//   Turns the ID-stage load-use hazard, the EX-stage taken-branch signal and
//   the data-memory busy signal into register write enables and bubble
//   (flush) controls. It also keeps a sticky memory-timeout flag and two
//   saturating performance counters.
//
// Parameters
//   BR_PENALTY  flush cycles per taken branch (1..3)
//   TIMEOUT     consecutive mem_busy cycles before mem_timeout sets (1..255)
//   CNT_W       width of the performance counters
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   hazard           load-use hazard from the ID-stage hazard detector
//   ex_branch_taken  EX-stage branch/jump resolved taken
//   mem_busy         data memory not ready; the whole pipeline freezes
//   pc_we            PC register write enable
//   ifid_we          IF/ID register write enable
//   ifid_flush       load a bubble into IF/ID
//   idex_flush       load a bubble into ID/EX
//   exmem_we         EX/MEM register write enable
//   memwb_we         MEM/WB register write enable
//   mem_timeout      sticky memory-timeout error flag
//   stall_cycles     cycles with pc_we=0 while out of reset (saturating)
//   flush_events     accepted taken branches (saturating)
//   ctrl_state       current state: RUN=0, REDIRECT=1, MEM_WAIT=2
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int BR_PENALTY = 2,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state, state_next, eff_state;
  logic [1:0] rem, rem_next;       // redirect flush cycles still owed
  logic [7:0] wait_cnt;            // consecutive mem_busy cycles
  logic [8:0] wait_sum;            // wait_cnt including the current cycle
  logic       branch_accept;

  assign ctrl_state = state;
  assign wait_sum   = {1'b0, wait_cnt} + 9'd1;

  // MEM_WAIT has no output behaviour of its own once memory is ready: that
  // cycle acts as the state being resumed. State encoding 3 acts as RUN.
  always_comb begin
    case (state)
      RUN:      eff_state = RUN;
      REDIRECT: eff_state = REDIRECT;
      MEM_WAIT: eff_state = (rem != 2'd0) ? REDIRECT : RUN;
      default:  eff_state = RUN;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    pc_we         = 1'b0;
    ifid_we       = 1'b0;
    exmem_we      = 1'b0;
    memwb_we      = 1'b0;
    ifid_flush    = 1'b1;
    idex_flush    = 1'b1;
    state_next    = RUN;
    rem_next      = rem;
    branch_accept = 1'b0;

    if (!rst_n) begin
      // Reset: hold everything and keep bubbles in the front stages.
    end else if (mem_busy) begin
      // Freeze: nothing moves, nothing is flushed, remainder is kept.
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      state_next = MEM_WAIT;
    end else begin
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      if (eff_state == REDIRECT) begin
        // Wrong-path fetch still in flight: keep squashing IF/ID only.
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_flush = 1'b0;
        rem_next   = (rem == 2'd0) ? 2'd0 : rem - 2'd1;
        state_next = (rem > 2'd1) ? REDIRECT : RUN;
      end else if (ex_branch_taken) begin
        // Branch outranks hazard: the hazarding instruction is squashed anyway.
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        branch_accept = 1'b1;
        if (BR_PENALTY > 1) begin
          state_next = REDIRECT;
          rem_next   = 2'(BR_PENALTY - 1);
        end
      end else if (hazard) begin
        // Load-use: hold PC and IF/ID, insert a bubble into ID/EX.
        ifid_flush = 1'b0;
      end else begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state        <= RUN;
      rem          <= 2'd0;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;

      if (mem_busy) begin
        if (wait_cnt != 8'hFF) wait_cnt <= wait_sum[7:0];
        if (wait_sum >= 9'(TIMEOUT)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end

      if (!pc_we && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (branch_accept && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int BR_PENALTY = 2;
  localparam int TIMEOUT    = 4;
  localparam int CNT_W      = 5;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hazard = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [1:0]       ctrl_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owed flush cycles, frozen flag, busy run length.
  int m_pending  = 0;
  bit m_frozen   = 0;
  int m_busy_run = 0;
  bit m_timeout  = 0;
  int m_stall    = 0;
  int m_flush    = 0;

  pipeline_ctrl #(
    .BR_PENALTY(BR_PENALTY),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard         (hazard),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_we       (exmem_we),
    .memwb_we       (memwb_we),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .ctrl_state     (ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after a rising edge, compare every
  // output on the falling edge, then advance the model at the rising edge.
  task automatic step(input bit r, input bit b, input bit br, input bit hz);
    bit [5:0] e;  // {pc, ifid, exmem, memwb, ifid_flush, idex_flush}
    rst_n = r; mem_busy = b; ex_branch_taken = br; hazard = hz;

    if (!r)                e = 6'b0000_11;
    else if (b)            e = 6'b0000_00;
    else if (m_pending > 0) e = 6'b1111_10;
    else if (br)           e = 6'b1111_11;
    else if (hz)           e = 6'b0011_01;
    else                   e = 6'b1111_00;

    @(negedge clk);
    check("pc_we",        32'(pc_we),        32'(e[5]));
    check("ifid_we",      32'(ifid_we),      32'(e[4]));
    check("exmem_we",     32'(exmem_we),     32'(e[3]));
    check("memwb_we",     32'(memwb_we),     32'(e[2]));
    check("ifid_flush",   32'(ifid_flush),   32'(e[1]));
    check("idex_flush",   32'(idex_flush),   32'(e[0]));
    check("ctrl_state",   32'(ctrl_state),
          m_frozen ? 32'd2 : (m_pending > 0 ? 32'd1 : 32'd0));
    check("mem_timeout",  32'(mem_timeout),  32'(m_timeout));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("flush_events", 32'(flush_events), 32'(m_flush));

    @(posedge clk);
    if (!r) begin
      m_pending = 0; m_frozen = 0; m_busy_run = 0;
      m_timeout = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (b) begin
        m_frozen = 1;
        if (m_busy_run < 255) m_busy_run++;
        if (m_busy_run >= TIMEOUT) m_timeout = 1;
      end else begin
        m_frozen = 0;
        m_busy_run = 0;
        if (m_pending > 0) m_pending--;
        else if (br) begin
          if (m_flush < CNT_MAX) m_flush++;
          m_pending = BR_PENALTY - 1;
        end
      end
      if (!e[5] && m_stall < CNT_MAX) m_stall++;
    end
    #1;
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_state", 32'(ctrl_state), 32'd0);
    step(1, 0, 0, 0);

    // Load-use stall
    step(1, 0, 0, 1);
    check("lu_stall", 32'(stall_cycles), 32'd1);
    check("lu_state", 32'(ctrl_state), 32'd0);

    // Taken branch, penalty 2
    step(1, 0, 1, 0);
    check("br_state1", 32'(ctrl_state), 32'd1);
    step(1, 0, 0, 0);
    check("br_state2", 32'(ctrl_state), 32'd0);
    check("br_flushes", 32'(flush_events), 32'd1);
    step(1, 0, 0, 0);

    // Branch beats hazard
    step(1, 0, 1, 1);
    check("bh_stall", 32'(stall_cycles), 32'd1);
    check("bh_flushes", 32'(flush_events), 32'd2);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Busy during redirect
    step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check("bd_state_wait", 32'(ctrl_state), 32'd2);
    end
    check("bd_stall", 32'(stall_cycles), 32'd4);
    step(1, 0, 0, 0);  // the remaining redirect cycle
    check("bd_state_run", 32'(ctrl_state), 32'd0);
    step(1, 0, 0, 0);

    // Timeout with TIMEOUT=4
    step(0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0, 0);
      check("to_flag", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("to_sticky", 32'(mem_timeout), 32'd1);

    // Reset mid-MEM_WAIT
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("rmw_stall", 32'(stall_cycles), 32'd0);
    check("rmw_flush", 32'(flush_events), 32'd0);
    check("rmw_timeout", 32'(mem_timeout), 32'd0);
    step(1, 0, 0, 0);
    check("rmw_state", 32'(ctrl_state), 32'd0);

    // Randomized traffic against the model (counters saturate along the way)
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
